// File: rtl/click_mux_n_pkg.sv
// click_pkg: shared state encoding and select-width helper for the N-way click mux.
// Data buses throughout are plain logic [W-1:0], with W carried as a module parameter.
package click_pkg;

  localparam int CLICK_DEFAULT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } mux_state_e;

  // Width of a channel index; at least one bit even for degenerate N.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/click_mux_n_if.sv
// click_mux_n_if: two-phase handshake bundle for N inputs, one select and one output.
// master = producers/select source/consumer side, slave = the mux.
interface click_mux_n_if
  import click_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SEL_W = sel_width(N);

  logic [N-1:0]     in_req;
  logic [N-1:0]     in_ack;
  logic [W-1:0]     in_data [N];
  logic             sel_req;
  logic             sel_ack;
  logic [SEL_W-1:0] sel_data;
  logic             out_req;
  logic             out_ack;
  logic [W-1:0]     out_data;

  modport master (
    output in_req, in_data, sel_req, sel_data, out_ack,
    input  in_ack, sel_ack, out_req, out_data
  );

  modport slave (
    input  in_req, in_data, sel_req, sel_data, out_ack,
    output in_ack, sel_ack, out_req, out_data
  );

endinterface

// File: rtl/click_mux_n_phase_reg.sv
// click_phase_reg: a single handshake phase flop that flips when toggle_en is high.
module click_phase_reg #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle_en,
  output logic phase
);

  logic phase_q, phase_d;

  always_comb begin
    phase_d = toggle_en ? ~phase_q : phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= INIT;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/click_mux_n.sv
// click_mux_n: clocked N-way two-phase multiplexer with registered output data.
// Define CLICK_MUX_SEL_CHECK_EN to consume out-of-range selects and raise a sticky sel_err.
module click_mux_n
  import click_pkg::*;
#(
  parameter int         N              = 4,
  parameter int         W              = 8,
  parameter logic [N-1:0] PHASE_INIT_IN  = '0,
  parameter logic       PHASE_INIT_SEL = 1'b0,
  parameter logic       PHASE_INIT_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  click_mux_n_if.slave  bus,
  output logic          busy,
  output logic          sel_err
);

  localparam int SEL_W = sel_width(N);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [W-1:0]     data_q, data_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     in_ack, in_ack_tgl;
  logic             sel_ack, sel_ack_tgl;
  logic             out_req, out_req_tgl;

  logic             sel_pend, out_free, in_range, in_pend;
  logic [SEL_W-1:0] idx_sel;

  // A power-of-two N cannot be addressed out of range, so no comparator is built.
  if ((1 << SEL_W) == N) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (int'(bus.sel_data) < N);
  end

  assign sel_pend = (bus.sel_req != sel_ack);
  assign out_free = (out_req == bus.out_ack);
  assign idx_sel  = in_range ? bus.sel_data : '0;
  assign in_pend  = (bus.in_req[idx_sel] != in_ack[idx_sel]);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    busy_d      = busy_q;
    in_ack_tgl  = '0;
    sel_ack_tgl = 1'b0;
    out_req_tgl = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_pend && in_range && in_pend) begin
          state_d     = ST_SEND;
          idx_d       = idx_sel;
          data_d      = bus.in_data[idx_sel];
          busy_d      = 1'b1;
          out_req_tgl = 1'b1;
        end
`ifdef CLICK_MUX_SEL_CHECK_EN
        else if (sel_pend && !in_range) begin
          sel_ack_tgl = 1'b1;
        end
`endif
      end
      ST_SEND: begin
        // Both acks complete together once the consumer has caught up.
        if (out_free) begin
          state_d           = ST_IDLE;
          busy_d            = 1'b0;
          in_ack_tgl[idx_q] = 1'b1;
          sel_ack_tgl       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_in_ack
    click_phase_reg #(.INIT(PHASE_INIT_IN[k])) u_in_ack (
      .clk       (clk),
      .rst       (rst),
      .toggle_en (in_ack_tgl[k]),
      .phase     (in_ack[k])
    );
  end

  click_phase_reg #(.INIT(PHASE_INIT_SEL)) u_sel_ack (
    .clk       (clk),
    .rst       (rst),
    .toggle_en (sel_ack_tgl),
    .phase     (sel_ack)
  );

  click_phase_reg #(.INIT(PHASE_INIT_OUT)) u_out_req (
    .clk       (clk),
    .rst       (rst),
    .toggle_en (out_req_tgl),
    .phase     (out_req)
  );

`ifdef CLICK_MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q | ((state_q == ST_IDLE) && sel_pend && !in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign bus.in_ack   = in_ack;
  assign bus.sel_ack  = sel_ack;
  assign bus.out_req  = out_req;
  assign bus.out_data = data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_click_mux_n.sv
// tb_click_mux_n: directed and randomized checks of click_mux_n against a transaction-level model.
// Exercises N=4 (zero and non-zero reset phases) and N=3 for out-of-range selects.
module tb_click_mux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  click_mux_n_if #(.N(4), .W(8)) b4 ();
  click_mux_n_if #(.N(3), .W(8)) b3 ();
  click_mux_n_if #(.N(4), .W(8)) bp ();

  logic busy4, err4, busy3, err3, busyp, errp;

  click_mux_n #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .bus(b4), .busy(busy4), .sel_err(err4)
  );

  click_mux_n #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy3), .sel_err(err3)
  );

  click_mux_n #(.N(4), .W(8), .PHASE_INIT_IN(4'b1010), .PHASE_INIT_SEL(1'b0),
                .PHASE_INIT_OUT(1'b1)) dutp (
    .clk(clk), .rst(rst), .bus(bp), .busy(busyp), .sel_err(errp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Transaction-level model state for the randomized phase.
  logic [3:0] ea;
  logic       es, eo;
  logic [3:0] pend;
  logic [7:0] pdata [4];

  initial begin
    b4.in_req = '0; b4.sel_req = 1'b0; b4.sel_data = '0; b4.out_ack = 1'b0;
    b3.in_req = '0; b3.sel_req = 1'b0; b3.sel_data = '0; b3.out_ack = 1'b0;
    bp.in_req = 4'b1010; bp.sel_req = 1'b0; bp.sel_data = '0; bp.out_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin b4.in_data[k] = '0; bp.in_data[k] = '0; end
    for (int k = 0; k < 3; k++) b3.in_data[k] = '0;

    repeat (2) @(negedge clk);
    chk("rst_in_ack", b4.in_ack, 4'b0000);
    chk("rst_sel_ack", b4.sel_ack, 1'b0);
    chk("rst_out_req", b4.out_req, 1'b0);
    chk("rst_out_data", b4.out_data, 8'h00);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_err", err4, 1'b0);
    chk("rstp_in_ack", bp.in_ack, 4'b1010);
    chk("rstp_out_req", bp.out_req, 1'b1);
    chk("rstp_sel_ack", bp.sel_ack, 1'b0);
    rst = 1'b0;

    // Non-zero reset phases: a channel-1 transfer drives in_ack[1] back to 0.
    bp.in_data[1] = 8'h3C; bp.in_req[1] = 1'b0; bp.sel_data = 2'd1; bp.sel_req = 1'b1;
    @(negedge clk);
    chk("p_launch_out_req", bp.out_req, 1'b0);
    chk("p_launch_data", bp.out_data, 8'h3C);
    chk("p_launch_busy", busyp, 1'b1);
    bp.out_ack = 1'b0;
    @(negedge clk);
    chk("p_done_in_ack", bp.in_ack, 4'b1000);
    chk("p_done_sel_ack", bp.sel_ack, 1'b1);
    chk("p_done_busy", busyp, 1'b0);

    // Basic transfer on channel 2.
    b4.in_data[2] = 8'hA5; b4.in_req[2] = 1'b1; b4.sel_data = 2'd2; b4.sel_req = 1'b1;
    @(negedge clk);
    chk("t1_out_req", b4.out_req, 1'b1);
    chk("t1_out_data", b4.out_data, 8'hA5);
    chk("t1_busy", busy4, 1'b1);
    chk("t1_no_ack", b4.in_ack, 4'b0000);
    b4.out_ack = 1'b1;
    @(negedge clk);
    chk("t1_in_ack", b4.in_ack, 4'b0100);
    chk("t1_sel_ack", b4.sel_ack, 1'b1);
    chk("t1_busy_done", busy4, 1'b0);

    // Two pending inputs served in select order 3 then 0.
    b4.in_data[0] = 8'h11; b4.in_req[0] = 1'b1;
    b4.in_data[3] = 8'h33; b4.in_req[3] = 1'b1;
    b4.sel_data = 2'd3; b4.sel_req = 1'b0;
    @(negedge clk);
    chk("t2a_out_req", b4.out_req, 1'b0);
    chk("t2a_out_data", b4.out_data, 8'h33);
    repeat (2) @(negedge clk);
    chk("t2a_hold_in_ack", b4.in_ack, 4'b0100);
    chk("t2a_hold_busy", busy4, 1'b1);
    b4.out_ack = 1'b0;
    @(negedge clk);
    chk("t2a_in_ack", b4.in_ack, 4'b1100);
    chk("t2a_sel_ack", b4.sel_ack, 1'b0);
    b4.sel_data = 2'd0; b4.sel_req = 1'b1;
    @(negedge clk);
    chk("t2b_out_req", b4.out_req, 1'b1);
    chk("t2b_out_data", b4.out_data, 8'h11);
    b4.out_ack = 1'b1;
    @(negedge clk);
    chk("t2b_in_ack", b4.in_ack, 4'b1101);
    chk("t2b_sel_ack", b4.sel_ack, 1'b1);

    // Select waits for its input.
    b4.sel_data = 2'd1; b4.sel_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_wait_out_req", b4.out_req, 1'b1);
    chk("t3_wait_busy", busy4, 1'b0);
    chk("t3_wait_sel_ack", b4.sel_ack, 1'b1);
    b4.in_data[1] = 8'h5C; b4.in_req[1] = 1'b1;
    @(negedge clk);
    chk("t3_out_req", b4.out_req, 1'b0);
    chk("t3_out_data", b4.out_data, 8'h5C);
    chk("t3_busy", busy4, 1'b1);
    b4.out_ack = 1'b0;
    @(negedge clk);
    chk("t3_in_ack", b4.in_ack, 4'b1111);
    chk("t3_sel_ack", b4.sel_ack, 1'b0);

    // Out-of-range select on N=3 with channel 0 pending.
    b3.in_data[0] = 8'h42; b3.in_req[0] = 1'b1; b3.sel_data = 2'd3; b3.sel_req = 1'b1;
    @(negedge clk);
`ifdef CLICK_MUX_SEL_CHECK_EN
    chk("oor_sel_ack", b3.sel_ack, 1'b1);
    chk("oor_err", err3, 1'b1);
`else
    chk("oor_sel_ack", b3.sel_ack, 1'b0);
    chk("oor_err", err3, 1'b0);
`endif
    chk("oor_in_ack", b3.in_ack, 3'b000);
    chk("oor_out_req", b3.out_req, 1'b0);
    chk("oor_busy", busy3, 1'b0);
    repeat (4) @(negedge clk);
`ifdef CLICK_MUX_SEL_CHECK_EN
    chk("oor_err_hold", err3, 1'b1);
    chk("oor_sel_ack_hold", b3.sel_ack, 1'b1);
`else
    chk("oor_err_hold", err3, 1'b0);
    chk("oor_sel_ack_hold", b3.sel_ack, 1'b0);
`endif
    chk("oor_out_req_hold", b3.out_req, 1'b0);

    // Reset while a token is in flight.
    b4.in_data[2] = 8'h77; b4.in_req[2] = 1'b0; b4.sel_data = 2'd2; b4.sel_req = 1'b1;
    @(negedge clk);
    chk("t4_busy", busy4, 1'b1);
    chk("t4_out_req", b4.out_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_in_ack", b4.in_ack, 4'b0000);
    chk("t4_rst_sel_ack", b4.sel_ack, 1'b0);
    chk("t4_rst_out_req", b4.out_req, 1'b0);
    chk("t4_rst_out_data", b4.out_data, 8'h00);
    chk("t4_rst_busy", busy4, 1'b0);
    rst = 1'b0;
    b4.out_ack = 1'b1;
    @(negedge clk);
    chk("t4_ign_busy", busy4, 1'b0);
    chk("t4_ign_out_req", b4.out_req, 1'b0);
    chk("t4_ign_in_ack", b4.in_ack, 4'b0000);
    chk("t4_ign_sel_ack", b4.sel_ack, 1'b0);
    b4.in_req = '0; b4.sel_req = 1'b0; b4.out_ack = 1'b0;
    @(negedge clk);

    // Randomized transfers with distractor channels, checked as transactions.
    ea = '0; es = 1'b0; eo = 1'b0; pend = '0;
    for (int k = 0; k < 4; k++) pdata[k] = '0;
    for (int it = 0; it < 40; it++) begin
      int c, o, gap;
      bit sel_first, need_in;
      c = int'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        o = (c + 1 + int'($urandom_range(0, 2))) % 4;
        if (!pend[o]) begin
          pdata[o] = 8'($urandom);
          b4.in_data[o] = pdata[o];
          b4.in_req[o] = ~b4.in_req[o];
          pend[o] = 1'b1;
        end
      end
      sel_first = bit'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      need_in = !pend[c];
      if (need_in) pdata[c] = 8'($urandom);
      if (sel_first || !need_in) begin
        b4.sel_data = 2'(c); b4.sel_req = ~b4.sel_req;
        if (need_in) begin
          repeat (gap) begin @(negedge clk); chk("rnd_idle_sel", b4.out_req, eo); end
          b4.in_data[c] = pdata[c]; b4.in_req[c] = ~b4.in_req[c];
        end
      end else begin
        b4.in_data[c] = pdata[c]; b4.in_req[c] = ~b4.in_req[c];
        repeat (gap) begin @(negedge clk); chk("rnd_idle_in", b4.out_req, eo); end
        b4.sel_data = 2'(c); b4.sel_req = ~b4.sel_req;
      end
      @(negedge clk);
      eo = ~eo;
      chk("rnd_launch", b4.out_req, eo);
      chk("rnd_data", b4.out_data, pdata[c]);
      chk("rnd_busy", busy4, 1'b1);
      chk("rnd_pre_ack", b4.in_ack, ea);
      repeat ($urandom_range(0, 3)) begin @(negedge clk); chk("rnd_busy_hold", busy4, 1'b1); end
      b4.out_ack = eo;
      @(negedge clk);
      ea[c] = ~ea[c]; es = ~es; pend[c] = 1'b0;
      chk("rnd_in_ack", b4.in_ack, ea);
      chk("rnd_sel_ack", b4.sel_ack, es);
      chk("rnd_done_busy", busy4, 1'b0);
    end
    chk("end_err", err4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
